// File: rtl/alu_pkg.sv
// Shared encodings for the sequential ALU: modes, per-mode options, flag
// bit positions and the control FSM state type.
package alu_pkg;

    localparam logic [1:0] MODE_ARITH = 2'b00;
    localparam logic [1:0] MODE_LOGIC = 2'b01;
    localparam logic [1:0] MODE_COMP  = 2'b10;
    localparam logic [1:0] MODE_MUL   = 2'b11;

    localparam logic [3:0] OPT_ADD  = 4'd0;
    localparam logic [3:0] OPT_SUB  = 4'd1;
    localparam logic [3:0] OPT_INC  = 4'd2;
    localparam logic [3:0] OPT_DEC  = 4'd3;

    localparam logic [3:0] OPT_AND  = 4'd0;
    localparam logic [3:0] OPT_OR   = 4'd1;
    localparam logic [3:0] OPT_XOR  = 4'd2;
    localparam logic [3:0] OPT_NOT  = 4'd3;
    localparam logic [3:0] OPT_NAND = 4'd4;
    localparam logic [3:0] OPT_NOR  = 4'd5;

    localparam logic [3:0] OPT_EQ   = 4'd0;
    localparam logic [3:0] OPT_GT   = 4'd1;
    localparam logic [3:0] OPT_LT   = 4'd2;
    localparam logic [3:0] OPT_SHL  = 4'd3;
    localparam logic [3:0] OPT_SHR  = 4'd4;
    localparam logic [3:0] OPT_ASR  = 4'd5;

    // flags = {carry, zero, neg, ovf}
    localparam int FLAG_CARRY = 3;
    localparam int FLAG_ZERO  = 2;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_OVF   = 0;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_comb_unit.sv
// Single-cycle datapath for arith, logic and compare/shift modes; flags
// an illegal mode/option combination through err with all outputs zeroed.
module alu_comb_unit import alu_pkg::*; #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic [3:0]       option,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    logic [SHW-1:0] shamt;
    logic [WIDTH:0] shl_ext;
    logic [WIDTH:0] shr_ext;
    logic [WIDTH:0] asr_ext;
    logic [WIDTH:0] sum;
    logic [WIDTH-1:0] rhs;
    logic carry;
    logic ovf;

    // One extra bit on each shift catches the last bit shifted out.
    assign shamt   = b[SHW-1:0];
    assign shl_ext = {1'b0, a} << shamt;
    assign shr_ext = {a, 1'b0} >> shamt;
    assign asr_ext = $signed({a, 1'b0}) >>> shamt;

    always_comb begin
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        err    = 1'b0;
        sum    = '0;
        rhs    = b;
        case (mode)
            MODE_ARITH: begin
                if (option == OPT_INC || option == OPT_DEC) begin
                    rhs = WIDTH'(1);
                end
                case (option)
                    OPT_ADD, OPT_INC: begin
                        sum = {1'b0, a} + {1'b0, rhs};
                        ovf = (a[MSB] == rhs[MSB]) && (sum[MSB] != a[MSB]);
                    end
                    OPT_SUB, OPT_DEC: begin
                        sum = {1'b0, a} - {1'b0, rhs};
                        ovf = (a[MSB] != rhs[MSB]) && (sum[MSB] != a[MSB]);
                    end
                    default: err = 1'b1;
                endcase
                result = sum[MSB:0];
                carry  = sum[WIDTH];
            end
            MODE_LOGIC: begin
                case (option)
                    OPT_AND:  result = a & b;
                    OPT_OR:   result = a | b;
                    OPT_XOR:  result = a ^ b;
                    OPT_NOT:  result = ~a;
                    OPT_NAND: result = ~(a & b);
                    OPT_NOR:  result = ~(a | b);
                    default:  err = 1'b1;
                endcase
            end
            MODE_COMP: begin
                case (option)
                    OPT_EQ: result = WIDTH'(a == b);
                    OPT_GT: result = WIDTH'(a > b);
                    OPT_LT: result = WIDTH'(a < b);
                    OPT_SHL: begin
                        result = shl_ext[MSB:0];
                        carry  = shl_ext[WIDTH];
                    end
                    OPT_SHR: begin
                        result = shr_ext[WIDTH:1];
                        carry  = shr_ext[0];
                    end
                    OPT_ASR: begin
                        result = asr_ext[WIDTH:1];
                        carry  = asr_ext[0];
                    end
                    default: err = 1'b1;
                endcase
            end
            default: err = (MUL_EN == 0);
        endcase

        flags = '0;
        if (err) begin
            result = '0;
        end else begin
            flags[FLAG_CARRY] = carry;
            flags[FLAG_ZERO]  = (result == '0);
            flags[FLAG_NEG]   = result[MSB];
            flags[FLAG_OVF]   = ovf;
        end
    end

endmodule

// File: rtl/alu_seq_core.sv
// Valid/ready ALU: one-cycle registered results for simple ops, plus an
// iterative shift-add multiplier that retires one multiplier bit per cycle.
module alu_seq_core import alu_pkg::*; #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic [1:0]       mode_sel,
    input  logic [3:0]       alu_option,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_data,
    output logic [WIDTH-1:0] alu_data_hi,
    output logic [3:0]       flags,
    output logic             err
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t state_reg, state_next;
    logic             out_valid_reg;
    logic [WIDTH-1:0] data_reg;
    logic [WIDTH-1:0] data_hi_reg;
    logic [3:0]       flags_reg;
    logic             err_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CW-1:0]      cnt_reg;

    logic [WIDTH-1:0] comb_result;
    logic [3:0]       comb_flags;
    logic             comb_err;
    logic             accept;
    logic             start_mul;
    logic             mul_done;
    logic [2*WIDTH-1:0] acc_step;
    logic [3:0]       mul_flags;

    alu_comb_unit #(
        .WIDTH  (WIDTH),
        .MUL_EN (MUL_EN)
    ) u_comb (
        .a      (operand_a),
        .b      (operand_b),
        .mode   (mode_sel),
        .option (alu_option),
        .result (comb_result),
        .flags  (comb_flags),
        .err    (comb_err)
    );

    assign in_ready  = (state_reg == IDLE) && (!out_valid_reg || out_ready);
    assign accept    = in_valid && in_ready;
    assign start_mul = accept && (mode_sel == MODE_MUL) && (MUL_EN != 0);
    assign mul_done  = (state_reg == MUL) && (cnt_reg == CNT_LAST);
    assign acc_step  = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    always_comb begin
        mul_flags             = '0;
        mul_flags[FLAG_ZERO]  = (acc_step == '0);
        mul_flags[FLAG_NEG]   = acc_step[2*WIDTH-1];
        mul_flags[FLAG_OVF]   = (acc_step[2*WIDTH-1:WIDTH] != '0);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_mul) state_next = MUL;
            MUL:     if (mul_done)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            data_reg      <= '0;
            data_hi_reg   <= '0;
            flags_reg     <= '0;
            err_reg       <= 1'b0;
            acc_reg       <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            cnt_reg       <= '0;
        end else begin
            if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (accept && !start_mul) begin
                out_valid_reg <= 1'b1;
                data_reg      <= comb_result;
                data_hi_reg   <= '0;
                flags_reg     <= comb_flags;
                err_reg       <= comb_err;
            end
            // Operands are latched here so input changes during MUL are ignored.
            if (start_mul) begin
                acc_reg    <= '0;
                mcand_reg  <= {{WIDTH{1'b0}}, operand_a};
                mplier_reg <= operand_b;
                cnt_reg    <= '0;
            end
            if (state_reg == MUL) begin
                acc_reg    <= acc_step;
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg + CW'(1);
                if (mul_done) begin
                    out_valid_reg <= 1'b1;
                    data_reg      <= acc_step[WIDTH-1:0];
                    data_hi_reg   <= acc_step[2*WIDTH-1:WIDTH];
                    flags_reg     <= mul_flags;
                    err_reg       <= 1'b0;
                end
            end
        end
    end

    assign out_valid   = out_valid_reg;
    assign alu_data    = data_reg;
    assign alu_data_hi = data_hi_reg;
    assign flags       = flags_reg;
    assign err         = err_reg;

endmodule

// File: doc/alu_seq_core.md
ALU_SEQ_CORE -- requirements
Module: alu_seq_core

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width; legal range 4..32.
REQ-002 Parameter MUL_EN, default 1, enables mode 2'b11 iterative multiply; when 0, mode 2'b11 is an illegal opcode.
REQ-003 clk  input  1  single clock for the block; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand/op bundle valid.
REQ-006 in_ready  output  1  block accepts a bundle this cycle.
REQ-007 operand_a, operand_b  input  WIDTH  operands, unsigned unless stated otherwise.
REQ-008 mode_sel  input  2  00 arith, 01 logic, 10 compare/shift, 11 multiply.
REQ-009 alu_option  input  4  operation within the selected mode.
REQ-010 out_valid  output  1  result bundle valid.
REQ-011 out_ready  input  1  consumer accepts result this cycle.
REQ-012 alu_data  output  WIDTH  result, low half for multiply.
REQ-013 alu_data_hi  output  WIDTH  multiply high half; 0 for all other modes.
REQ-014 flags  output  4  {carry, zero, neg, ovf}.
REQ-015 err  output  1  illegal mode/option for the current result.

Function
REQ-016 A transfer occurs when in_valid && in_ready; the output transfer occurs when out_valid && out_ready.
REQ-017 in_ready = (state==IDLE) && (!out_valid || out_ready); full throughput of one op per cycle for non-multiply ops.
REQ-018 Arith options: 0 ADD a+b; 1 SUB a-b; 2 INC a+1; 3 DEC a-1; carry = carry-out of the WIDTH-bit add, or borrow for SUB/DEC; ovf = two's-complement overflow.
REQ-019 Logic options: 0 AND; 1 OR; 2 XOR; 3 NOT a; 4 NAND; 5 NOR; carry = ovf = 0.
REQ-020 Compare/shift options: 0 EQ, 1 GT, 2 LT (unsigned, result 1 or 0 in bit 0); 3 SHL a by b[log2(WIDTH)-1:0] bits; 4 SHR logical; 5 ASR; carry = last bit shifted out, 0 for shift amount 0.
REQ-021 zero = (alu_data==0 && alu_data_hi==0); neg = MSB of alu_data (MSB of alu_data_hi for multiply).
REQ-022 Any unlisted option, or mode 11 with MUL_EN=0, completes in one cycle with alu_data=0, alu_data_hi=0, flags=0, err=1; err=0 otherwise.
REQ-023 Non-multiply latency: a result accepted at edge N is presented with out_valid=1 after edge N (registered output, one cycle).
REQ-024 Multiply: unsigned shift-add FSM IDLE -> MUL (WIDTH iterations, one bit per cycle) -> IDLE with out_valid set; latency is WIDTH+1 cycles from acceptance to out_valid; in_ready=0 throughout MUL.
REQ-025 Multiply flags: carry = 0, ovf = (alu_data_hi != 0).
REQ-026 While out_valid=1 and out_ready=0, alu_data, alu_data_hi, flags and err hold stable; a new bundle is not accepted.
REQ-027 Simultaneous output drain and input accept in the same cycle is legal; the new result replaces the old one with no bubble.
REQ-028 Operands are captured at acceptance; input changes during MUL do not affect the result.

Reset
REQ-029 On rst_n=0, immediately: state=IDLE, out_valid=0, alu_data=0, alu_data_hi=0, flags=0, err=0, multiply accumulator and counter cleared.
REQ-030 Reset asserted mid-multiply aborts the operation; no result is emitted after release.
REQ-031 in_ready=1 in the first cycle after reset release.

Structure
REQ-032 Shared package alu_pkg holds mode encodings (MODE_ARITH, MODE_LOGIC, MODE_COMP, MODE_MUL), option constants, the flag bit indices, and the FSM state typedef.
REQ-033 Combinational single-cycle datapath in sub-module alu_comb_unit (WIDTH parameter) computing result, flags and err; the FSM, multiplier and output register live in alu_seq_core.

Verification (WIDTH=8)
REQ-034 ADD a=0xFF, b=0x01, out_ready=1 -> next cycle alu_data=0x00, carry=1, zero=1, ovf=0, err=0.
REQ-035 SUB a=0x80, b=0x01 -> alu_data=0x7F, ovf=1, neg=0, carry=0.
REQ-036 MUL a=0xFF, b=0xFF -> in_ready=0 for 8 cycles, out_valid 9 cycles after acceptance, {hi,lo}=0xFE01, ovf=1.
REQ-037 Back-to-back ADD/XOR/SHL with out_ready held 0 for 3 cycles -> first result held stable, in_ready=0, no result lost or duplicated after release.
REQ-038 mode 10, option 0xF -> alu_data=0, err=1; next legal op clears err.
REQ-039 rst_n pulsed low at MUL iteration 4 -> outputs 0 immediately, no out_valid after release, in_ready=1 in the next cycle.
